mux_4to1_rr_arbiter: RTL and testbench



---
 rtl/mux_4to1_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux_4to1_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 data mux.
// One requester is granted per packet; its data is presented on a
// valid/ready output until end-of-packet, a beat-count limit, or withdrawal.
module mux_4to1_rr_arbiter #(
   parameter int WIDTH     = 4,
   parameter int MAX_BEATS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [3:0]       last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             out_ready,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             out_last
);

   localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [3:0]      gnt_q, gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Index 0 = a ... 3 = d, same ordering as the original case mux.
   logic [3:0][WIDTH-1:0] data;
   assign data = {d, c, b, a};

   logic [1:0] win;
   logic [1:0] idx;
   logic       found;
   logic       busy;
   logic       cnt_max;
   logic       xfer;

   // Rotating priority scan starting at ptr; first requesting index wins.
   always_comb begin
      win   = ptr_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // Output datapath: purely a function of registered sel/state and live inputs.
   always_comb begin
      busy      = (state_q == BUSY);
      cnt_max   = (cnt_q == CW'(MAX_BEATS - 1));
      out       = busy ? data[sel_q] : '0;
      out_valid = busy & req[sel_q];
      out_last  = out_valid & (last[sel_q] | cnt_max);
      xfer      = out_valid & out_ready;
   end

   // Grant sequencing: arbitrate in IDLE, count beats and release in BUSY.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            cnt_d = '0;
            if (found) begin
               sel_d   = win;
               gnt_d   = 4'b0001 << win;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Withdrawal or a completed last beat both end the grant; sel is
            // kept so the external mux stays stable through the bubble.
            if (!req[sel_q] || (xfer && out_last)) begin
               state_d = IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
               ptr_d   = sel_q + 2'd1;
            end else if (xfer) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset clears everything immediately, dropping any packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt = gnt_q;
   assign sel = sel_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Table-driven check of the round-robin mux arbiter plus a beat scoreboard.
module tb_mux_4to1_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, last;
   logic [3:0] a, b, c, d;
   logic       out_ready;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic [3:0] out;
   logic       out_valid, out_last;

   int total = 0;
   int bad   = 0;

   mux_4to1_rr_arbiter #(.WIDTH(4), .MAX_BEATS(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .a(a), .b(b), .c(c), .d(d), .out_ready(out_ready),
      .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic [3:0] e_gnt;
      logic       e_vld;
      logic [3:0] e_out;
      logic       e_lst;
   } vec_t;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] out;
      logic       lst;
   } beat_t;

   vec_t  vt[$];
   beat_t sb[$];

   function automatic void r(input logic rs, input logic [3:0] rq, input logic [3:0] ls,
                             input logic rd, input logic [3:0] g, input logic v,
                             input logic [3:0] o, input logic l);
      vec_t x;
      x.rst_n = rs; x.req = rq; x.last = ls; x.rdy = rd;
      x.e_gnt = g; x.e_vld = v; x.e_out = o; x.e_lst = l;
      vt.push_back(x);
   endfunction

   function automatic logic [1:0] oh2idx(input logic [3:0] g);
      logic [1:0] k;
      k = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) k = 2'(i);
      return k;
   endfunction

   // Scoreboard: every accepted beat must match the oldest expected beat.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: got sel=%0d out=%0h last=%0b, required no beat",
                     sel, out, out_last);
         end else begin
            beat_t e;
            e = sb.pop_front();
            if (sel !== e.sel || out !== e.out || out_last !== e.lst) begin
               bad++;
               $display("FAIL beat: got sel=%0d out=%0h last=%0b, required sel=%0d out=%0h last=%0b",
                        sel, out, out_last, e.sel, e.out, e.lst);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g;
      a = 4'd1; b = 4'd2; c = 4'd4; d = 4'd8;
      req = '0; last = '0; out_ready = 1'b1; rst_n = 1'b0;

      // reset with toggling inputs
      r(0, 4'hF, 4'hF, 1, 0, 0, 0, 0);
      r(0, 4'h5, 4'hA, 0, 0, 0, 0, 0);
      r(1, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      // single requester a: 3 beats, last on the 3rd
      r(1, 4'h1, 4'h0, 1, 0, 0, 0, 0);
      r(1, 4'h1, 4'h0, 1, 1, 1, 1, 0);
      r(1, 4'h1, 4'h0, 1, 1, 1, 1, 0);
      r(1, 4'h1, 4'h1, 1, 1, 1, 1, 1);
      r(1, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      // all requesting with ptr=1: b,c,d,a,b with bubbles
      r(1, 4'hF, 4'hF, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         g = 4'b0001 << (k % 4);
         r(1, 4'hF, 4'hF, 1, g, 1, g, 1);
         if (k != 5) r(1, 4'hF, 4'hF, 1, 0, 0, 0, 0);
      end
      r(1, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      // reset restores ptr=0: a,b,c,d,a
      r(0, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      r(1, 4'hF, 4'hF, 1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         g = 4'b0001 << (k % 4);
         r(1, 4'hF, 4'hF, 1, g, 1, g, 1);
         if (k != 4) r(1, 4'hF, 4'hF, 1, 0, 0, 0, 0);
      end
      r(1, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      // forced release of c after 8 beats, regrant, then withdrawal
      r(1, 4'h4, 4'h0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) r(1, 4'h4, 4'h0, 1, 4, 1, 4, (k == 7));
      r(1, 4'h4, 4'h0, 1, 0, 0, 0, 0);
      r(1, 4'h4, 4'h0, 1, 4, 1, 4, 0);
      r(1, 4'h0, 4'h0, 1, 4, 0, 4, 0);
      r(1, 4'h0, 4'h0, 1, 0, 0, 0, 0);
      // backpressure on d: count frozen, so 8 beats total with stall
      r(1, 4'h8, 4'h0, 1, 0, 0, 0, 0);
      r(1, 4'h8, 4'h0, 1, 8, 1, 8, 0);
      for (int k = 0; k < 5; k++) r(1, 4'h8, 4'h0, 0, 8, 1, 8, 0);
      for (int k = 0; k < 7; k++) r(1, 4'h8, 4'h0, 1, 8, 1, 8, (k == 6));
      // regrant d, withdraw mid-packet, ptr wraps to 0 so a beats d
      r(1, 4'h8, 4'h0, 1, 0, 0, 0, 0);
      r(1, 4'h8, 4'h0, 1, 8, 1, 8, 0);
      r(1, 4'h0, 4'h0, 1, 8, 0, 8, 0);
      r(1, 4'h9, 4'h0, 1, 0, 0, 0, 0);
      r(1, 4'h9, 4'h1, 1, 1, 1, 1, 1);
      r(1, 4'h0, 4'h0, 1, 0, 0, 0, 0);

      #1;
      foreach (vt[i]) begin
         rst_n = vt[i].rst_n; req = vt[i].req; last = vt[i].last; out_ready = vt[i].rdy;
         if (vt[i].rst_n && vt[i].e_vld && vt[i].rdy) begin
            beat_t e;
            e.sel = oh2idx(vt[i].e_gnt); e.out = vt[i].e_out; e.lst = vt[i].e_lst;
            sb.push_back(e);
         end
         @(negedge clk);
         total++;
         if ({gnt, out_valid, out, out_last} !== {vt[i].e_gnt, vt[i].e_vld, vt[i].e_out, vt[i].e_lst}) begin
            bad++;
            $display("FAIL row%0d: got gnt=%b vld=%b out=%0h last=%b, required gnt=%b vld=%b out=%0h last=%b",
                     i, gnt, out_valid, out, out_last,
                     vt[i].e_gnt, vt[i].e_vld, vt[i].e_out, vt[i].e_lst);
         end
         @(posedge clk); #1;
      end

      // asynchronous reset in the middle of a grant clears without a clock edge
      req = 4'h2; last = 4'h0; out_ready = 1'b0;
      @(posedge clk); #1;
      total++;
      if (gnt !== 4'b0010 || sel !== 2'd1 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL busy_before_reset: got gnt=%b sel=%0d vld=%b, required gnt=0010 sel=1 vld=1",
                  gnt, sel, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({gnt, sel, out_valid, out, out_last} !== 12'd0) begin
         bad++;
         $display("FAIL async_reset: got gnt=%b sel=%0d vld=%b out=%0h last=%b, required all zero",
                  gnt, sel, out_valid, out, out_last);
      end
      @(posedge clk); #1;
      req = 4'h0; rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL after_reset: got gnt=%b vld=%b, required gnt=0000 vld=0", gnt, out_valid);
      end

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d beats outstanding, required 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
